// File: rtl/fabric_cfg_loader.sv
// fabric_cfg_loader: serializes configuration words MSB-first into a clb_tile chain and commits them with a set pulse
module fabric_cfg_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1000,
    parameter int SETTLE    = 2,
    parameter int TIMEOUT   = 1024,
    localparam int BW       = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              cfg_shift_en,
    output logic              cfg_shift_out,
    output logic              cfg_set,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [BW-1:0]     bits_left
);
    localparam int WBW = $clog2(WORD_W + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int SW  = SETTLE > 1 ? $clog2(SETTLE + 1) : 1;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_SETTLE, S_SET, S_DONE, S_ERR} state_t;
    state_t state, state_n;
    logic [WORD_W-1:0] sreg, sreg_n;
    logic [BW-1:0] bits_n;
    logic [WBW-1:0] wbits, wbits_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [SW-1:0] scnt, scnt_n;
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        bits_n  = bits_left;
        wbits_n = wbits;
        tmo_n   = tmo;
        scnt_n  = scnt;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_n = S_LOAD;
                    bits_n  = BW'(CHAIN_LEN);
                    tmo_n   = '0;
                end
            end
            S_LOAD: begin
                if (cfg_valid) begin
                    state_n = S_SHIFT;
                    sreg_n  = cfg_data;
                    tmo_n   = '0;
                    wbits_n = 32'(bits_left) >= 32'(WORD_W) ? WBW'(WORD_W) : WBW'(bits_left);
                end else if (tmo == TW'(TIMEOUT)) begin
                    state_n = S_ERR;
                end else begin
                    tmo_n = tmo + 1'b1;
                end
            end
            S_SHIFT: begin
                // a short final word simply stops early; its low bits are never shifted
                sreg_n  = sreg << 1;
                bits_n  = bits_left - 1'b1;
                wbits_n = wbits - 1'b1;
                scnt_n  = '0;
                if (wbits == WBW'(1))
                    state_n = bits_left != BW'(1) ? S_LOAD : SETTLE == 0 ? S_SET : S_SETTLE;
            end
            S_SETTLE: begin
                scnt_n = scnt + 1'b1;
                if (scnt == SW'(SETTLE > 0 ? SETTLE - 1 : 0))
                    state_n = S_SET;
            end
            S_SET:   state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end
    // outputs are decoded from the next state so every port comes straight from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            sreg          <= '0;
            bits_left     <= BW'(CHAIN_LEN);
            wbits         <= '0;
            tmo           <= '0;
            scnt          <= '0;
            cfg_ready     <= 1'b0;
            cfg_shift_en  <= 1'b0;
            cfg_shift_out <= 1'b0;
            cfg_set       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_n;
            sreg          <= sreg_n;
            bits_left     <= bits_n;
            wbits         <= wbits_n;
            tmo           <= tmo_n;
            scnt          <= scnt_n;
            cfg_ready     <= state_n == S_LOAD;
            cfg_shift_en  <= state_n == S_SHIFT;
            cfg_shift_out <= state_n == S_SHIFT && sreg_n[WORD_W-1];
            cfg_set       <= state_n == S_SET;
            busy          <= state_n inside {S_LOAD, S_SHIFT, S_SETTLE, S_SET};
            done          <= state_n == S_DONE;
            err           <= state_n == S_ERR;
        end
    end
endmodule

// File: tb/tb_fabric_cfg_loader.sv
// tb_fabric_cfg_loader: scoreboard bench for a 40-bit chain loader and a single-word, no-settle loader
module tb_fabric_cfg_loader;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;
    logic start_a = 0, valid_a = 0;
    logic [15:0] data_a = '0;
    logic rdy_a, sen_a, sout_a, cset_a, busy_a, done_a, err_a;
    logic [5:0] left_a;
    logic start_b = 0, valid_b = 0;
    logic [15:0] data_b = '0;
    logic rdy_b, sen_b, sout_b, cset_b, busy_b, done_b, err_b;
    logic [4:0] left_b;
    fabric_cfg_loader #(.WORD_W(16), .CHAIN_LEN(40), .SETTLE(2), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .cfg_data(data_a), .cfg_valid(valid_a),
        .cfg_ready(rdy_a), .cfg_shift_en(sen_a), .cfg_shift_out(sout_a), .cfg_set(cset_a),
        .busy(busy_a), .done(done_a), .err(err_a), .bits_left(left_a));
    fabric_cfg_loader #(.WORD_W(16), .CHAIN_LEN(16), .SETTLE(0), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .cfg_data(data_b), .cfg_valid(valid_b),
        .cfg_ready(rdy_b), .cfg_shift_en(sen_b), .cfg_shift_out(sout_b), .cfg_set(cset_b),
        .busy(busy_b), .done(done_b), .err(err_b), .bits_left(left_b));
    int total = 0, bad = 0, cyc = 0;
    bit q[$];
    logic e;
    int shift_cnt = 0, set_cnt = 0, set_cyc = 0, last_shift = 0, pushed = 0;
    int nshift_b = 0, nset_b = 0, set_cyc_b = 0, last_b = 0;
    logic [15:0] got_b = '0;
    bit abort = 0;
    logic [15:0] wv [3] = '{16'hA5A5, 16'h0F0F, 16'hC3FF};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (sen_a) begin
            shift_cnt++;
            last_shift = cyc;
            e = q.size() > 0 ? q.pop_front() : !sout_a;
            check("bit", sout_a, e);
        end
        if (cset_a) begin
            set_cnt++;
            set_cyc = cyc;
        end
        if (sen_b) begin
            nshift_b++;
            last_b = cyc;
            got_b = {got_b[14:0], sout_b};
        end
        if (cset_b) begin
            nset_b++;
            set_cyc_b = cyc;
        end
    end
    task automatic run_load(input logic [15:0] w [3], input int stall_word, input int exp_cyc);
        int t0, n;
        shift_cnt = 0;
        set_cnt = 0;
        pushed = 0;
        @(posedge clk); #1 start_a = 1; t0 = cyc;
        @(posedge clk); #1 start_a = 0;
        @(negedge clk);
        check("busy_on_start", busy_a, 1);
        check("done_drop", done_a, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == stall_word) begin
                valid_a = 0;
                for (int s = 0; s < 5; s++) begin
                    n = 0;
                    while (!rdy_a && !abort && n < 100) begin @(negedge clk); n++; end
                    if (abort) return;
                    check("stall_left", left_a, 40 - 16 * i);
                    check("stall_sen", sen_a, 0);
                    @(negedge clk);
                end
            end
            valid_a = 1;
            data_a = w[i];
            n = 0;
            while (!rdy_a && !abort && n < 100) begin @(negedge clk); n++; end
            if (abort) return;
            check("ready_wait", n < 100, 1);
            for (int j = 0; j < 16 && pushed < 40; j++) begin
                q.push_back(w[i][15-j]);
                pushed++;
            end
            @(posedge clk); #1 valid_a = 0;
        end
        n = 0;
        while (!done_a && !abort && n < 200) begin @(negedge clk); n++; end
        if (abort) return;
        check("done", done_a, 1);
        check("shift_cnt", shift_cnt, 40);
        check("set_cnt", set_cnt, 1);
        check("set_time", set_cyc - t0, exp_cyc);
        check("settle_gap", set_cyc - last_shift, 3);
        check("q_empty", q.size(), 0);
        check("left_zero", left_a, 0);
        check("busy_off", busy_a, 0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int n, t0;
        repeat (3) @(negedge clk);
        check("rst_outs", {rdy_a, sen_a, sout_a, cset_a, busy_a, done_a, err_a}, 0);
        check("rst_left", left_a, 40);
        check("rst_left_b", left_b, 16);
        #2 rst_n = 1;
        run_load(wv, -1, 46);
        run_load(wv, 1, 51);
        fork
            run_load(wv, -1, 46);
            begin
                n = 0;
                while (!sen_a && n < 100) begin @(negedge clk); n++; end
                start_a = 1;
                @(posedge clk); #1 start_a = 0;
                n = 0;
                while (!cset_a && n < 100) begin @(negedge clk); n++; end
                start_a = 1;
                @(posedge clk); #1 start_a = 0;
            end
        join
        repeat (3) @(negedge clk);
        check("done_hold", done_a, 1);
        check("ignored_start_sets", set_cnt, 1);
        run_load(wv, -1, 46);
        shift_cnt = 0;
        set_cnt = 0;
        @(posedge clk); #1 start_a = 1;
        @(posedge clk); #1 start_a = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("err_timing", err_a, i == 9);
            check("ready_tmo", rdy_a, i != 9);
        end
        check("tmo_quiet", shift_cnt + set_cnt, 0);
        run_load(wv, -1, 46);
        fork
            run_load(wv, -1, 46);
            begin
                n = 0;
                while (!(sen_a && left_a == 17) && n < 200) begin @(negedge clk); n++; end
                check("reach17", left_a, 17);
                check("set_before_rst", set_cnt, 0);
                #2 rst_n = 0; abort = 1;
                #1 check("async_outs", {rdy_a, sen_a, sout_a, cset_a, busy_a, done_a, err_a}, 0);
                check("async_left", left_a, 40);
            end
        join
        valid_a = 0;
        repeat (2) @(negedge clk);
        check("rst_no_set", set_cnt, 0);
        #2 rst_n = 1;
        q.delete();
        abort = 0;
        run_load(wv, -1, 46);
        @(posedge clk); #1 start_b = 1; t0 = cyc;
        @(posedge clk); #1 start_b = 0; valid_b = 1; data_b = 16'h9C3B;
        n = 0;
        while (!done_b && n < 100) begin @(negedge clk); n++; end
        check("b_done", done_b, 1);
        check("b_stream", got_b, 16'h9C3B);
        check("b_shifts", nshift_b, 16);
        check("b_sets", nset_b, 1);
        check("b_set_time", set_cyc_b - t0, 18);
        check("b_set_gap", set_cyc_b - last_b, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
